// File: rtl/ysyx_25020047_idu_pipe.sv
// ysyx_25020047_idu_pipe: pipelined RV32I/E decode stage with GPR file, write-back bypass and busy scoreboard
module ysyx_25020047_idu_pipe #(
  parameter int XLEN = 32,
  parameter int NR_REG = 32,
  localparam int AW = $clog2(NR_REG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [5:0]      out_op,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [AW-1:0]   out_rd,
  output logic            out_rd_wen,
  output logic            out_ebreak,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data
);
  localparam logic [5:0] OP_ILL = 6'd0, OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3, OP_JALR = 6'd4,
    OP_BEQ = 6'd5, OP_BNE = 6'd6, OP_BLT = 6'd7, OP_BGE = 6'd8, OP_BLTU = 6'd9, OP_BGEU = 6'd10,
    OP_LB = 6'd11, OP_LH = 6'd12, OP_LW = 6'd13, OP_LBU = 6'd14, OP_LHU = 6'd15,
    OP_SB = 6'd16, OP_SH = 6'd17, OP_SW = 6'd18,
    OP_ADDI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_ORI = 6'd23, OP_ANDI = 6'd24,
    OP_SLLI = 6'd25, OP_SRLI = 6'd26, OP_SRAI = 6'd27,
    OP_ADD = 6'd28, OP_SUB = 6'd29, OP_SLL = 6'd30, OP_SLT = 6'd31, OP_SLTU = 6'd32, OP_XOR = 6'd33,
    OP_SRL = 6'd34, OP_SRA = 6'd35, OP_OR = 6'd36, OP_AND = 6'd37,
    OP_FENCE = 6'd38, OP_ECALL = 6'd39, OP_EBREAK = 6'd40;
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;
  localparam logic [5:0] NR = 6'(NR_REG);

  logic [6:0] opc, f7;
  logic [2:0] f3, fmt;
  logic [4:0] rs1_f, rs2_f, rd_f;
  logic [5:0] op_raw, op;
  logic u1, u2, ud, r1_in, r2_in, rd_in, bad, rd_wen, hazard, fire, sb_set;
  logic [AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] imm, src1, src2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] gpr [NR_REG];
  logic [NR_REG-1:0] busy, blk, set_v, clr_v;

  assign {f7, rs2_f, rs1_f, f3, rd_f, opc} = in_inst;

  always_comb begin
    op_raw = OP_ILL;
    fmt = F_R;
    u1 = 1'b0;
    u2 = 1'b0;
    ud = 1'b0;
    case (opc)
      7'b0110111: begin op_raw = OP_LUI; fmt = F_U; ud = 1'b1; end
      7'b0010111: begin op_raw = OP_AUIPC; fmt = F_U; ud = 1'b1; end
      7'b1101111: begin op_raw = OP_JAL; fmt = F_J; ud = 1'b1; end
      7'b1100111: begin op_raw = f3 == 3'd0 ? OP_JALR : OP_ILL; fmt = F_I; u1 = 1'b1; ud = 1'b1; end
      7'b1100011: begin
        fmt = F_B;
        u1 = 1'b1;
        u2 = 1'b1;
        case (f3)
          3'd0: op_raw = OP_BEQ;
          3'd1: op_raw = OP_BNE;
          3'd4: op_raw = OP_BLT;
          3'd5: op_raw = OP_BGE;
          3'd6: op_raw = OP_BLTU;
          3'd7: op_raw = OP_BGEU;
          default: op_raw = OP_ILL;
        endcase
      end
      7'b0000011: begin
        fmt = F_I;
        u1 = 1'b1;
        ud = 1'b1;
        case (f3)
          3'd0: op_raw = OP_LB;
          3'd1: op_raw = OP_LH;
          3'd2: op_raw = OP_LW;
          3'd4: op_raw = OP_LBU;
          3'd5: op_raw = OP_LHU;
          default: op_raw = OP_ILL;
        endcase
      end
      7'b0100011: begin
        fmt = F_S;
        u1 = 1'b1;
        u2 = 1'b1;
        op_raw = f3 == 3'd0 ? OP_SB : f3 == 3'd1 ? OP_SH : f3 == 3'd2 ? OP_SW : OP_ILL;
      end
      7'b0010011: begin
        fmt = F_I;
        u1 = 1'b1;
        ud = 1'b1;
        case (f3)
          3'd0: op_raw = OP_ADDI;
          3'd1: op_raw = f7 == 7'h00 ? OP_SLLI : OP_ILL;
          3'd2: op_raw = OP_SLTI;
          3'd3: op_raw = OP_SLTIU;
          3'd4: op_raw = OP_XORI;
          3'd5: op_raw = f7 == 7'h00 ? OP_SRLI : f7 == 7'h20 ? OP_SRAI : OP_ILL;
          3'd6: op_raw = OP_ORI;
          default: op_raw = OP_ANDI;
        endcase
      end
      7'b0110011: begin
        fmt = F_R;
        u1 = 1'b1;
        u2 = 1'b1;
        ud = 1'b1;
        case (f3)
          3'd0: op_raw = f7 == 7'h00 ? OP_ADD : f7 == 7'h20 ? OP_SUB : OP_ILL;
          3'd1: op_raw = f7 == 7'h00 ? OP_SLL : OP_ILL;
          3'd2: op_raw = f7 == 7'h00 ? OP_SLT : OP_ILL;
          3'd3: op_raw = f7 == 7'h00 ? OP_SLTU : OP_ILL;
          3'd4: op_raw = f7 == 7'h00 ? OP_XOR : OP_ILL;
          3'd5: op_raw = f7 == 7'h00 ? OP_SRL : f7 == 7'h20 ? OP_SRA : OP_ILL;
          3'd6: op_raw = f7 == 7'h00 ? OP_OR : OP_ILL;
          default: op_raw = f7 == 7'h00 ? OP_AND : OP_ILL;
        endcase
      end
      7'b0001111: begin op_raw = OP_FENCE; fmt = F_I; end
      7'b1110011: begin
        fmt = F_I;
        op_raw = in_inst == 32'h0000_0073 ? OP_ECALL : in_inst == 32'h0010_0073 ? OP_EBREAK : OP_ILL;
      end
      default: op_raw = OP_ILL;
    endcase
  end

  // register fields beyond NR_REG make the instruction illegal and are excluded from hazard checks
  assign r1_in = {1'b0, rs1_f} < NR;
  assign r2_in = {1'b0, rs2_f} < NR;
  assign rd_in = {1'b0, rd_f} < NR;
  assign bad = (u1 && !r1_in) || (u2 && !r2_in) || (ud && !rd_in);
  assign op = bad ? OP_ILL : op_raw;
  assign rs1 = rs1_f[AW-1:0];
  assign rs2 = rs2_f[AW-1:0];
  assign rd = ud ? rd_f[AW-1:0] : '0;
  assign rd_wen = op != OP_ILL && ud && rd_f != 5'd0;

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign imm = fmt == F_I ? imm_i : fmt == F_S ? imm_s : fmt == F_B ? imm_b :
               fmt == F_U ? imm_u : fmt == F_J ? imm_j : '0;

  assign src1 = rs1 == '0 ? '0 : (wb_valid && wb_rd == rs1) ? wb_data : gpr[rs1];
  assign src2 = rs2 == '0 ? '0 : (wb_valid && wb_rd == rs2) ? wb_data : gpr[rs2];

  // a busy bit released by this cycle's write-back no longer blocks
  for (genvar i = 0; i < NR_REG; i++) begin : g_blk
    assign blk[i] = (busy[i] && !(wb_valid && wb_rd == AW'(i))) || (out_valid && out_rd_wen && out_rd == AW'(i));
  end

  assign hazard = (u1 && r1_in && blk[rs1]) || (u2 && r2_in && blk[rs2]) || (ud && rd_in && blk[rd]);
  assign in_ready = rst && (!out_valid || out_ready) && !hazard && !flush;
  assign fire = in_valid && in_ready;
  assign sb_set = out_valid && out_ready && out_rd_wen && !flush;
  assign set_v = NR_REG'(sb_set) << out_rd;
  assign clr_v = NR_REG'(wb_valid) << wb_rd;

  always_ff @(posedge clk or negedge rst)
    if (!rst) busy <= '0;
    else busy <= (busy & ~clr_v) | set_v;

  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int k = 0; k < NR_REG; k++) gpr[k] <= '0;
    else if (wb_valid && wb_rd != '0) gpr[wb_rd] <= wb_data;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_op <= '0;
      out_fmt <= '0;
      out_imm <= '0;
      out_src1 <= '0;
      out_src2 <= '0;
      out_rd <= '0;
      out_rd_wen <= 1'b0;
      out_ebreak <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_pc <= in_pc;
      out_op <= op;
      out_fmt <= fmt;
      out_imm <= imm;
      out_src1 <= src1;
      out_src2 <= src2;
      out_rd <= rd;
      out_rd_wen <= rd_wen;
      out_ebreak <= op == OP_EBREAK;
    end else if (flush || out_ready) out_valid <= 1'b0;
endmodule
